// File: rtl/sobel_gradient_engine.sv
// sobel_gradient_engine: streaming 3x3 Sobel front end for raster-order 8-bit RGB.
// Each accepted pixel yields one signed 10-bit gradient per channel, two cycles later.
// KERNEL_DIR selects Gx (0) or Gy (1).
// Optional build macro SOBEL_BORDER_MASK_EN: force results to zero when the
// window is not fully inside the current frame (input row < 2 or column < 2).
module sobel_gradient_engine #(
    parameter int IMAGE_WIDTH = 640,
    parameter int KERNEL_DIR  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [7:0]        in_red,
    input  logic [7:0]        in_green,
    input  logic [7:0]        in_blue,
    output logic              out_valid,
    output logic signed [9:0] red_output,
    output logic signed [9:0] green_output,
    output logic signed [9:0] blue_output
);
    localparam int COL_W = $clog2(IMAGE_WIDTH);
    localparam int NCH   = 3;

    typedef logic [7:0] pix_t;

    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  col_idx;
    logic [1:0]        row;
    pix_t              new_px   [NCH];
    pix_t              linebuf0 [NCH][IMAGE_WIDTH];
    pix_t              linebuf1 [NCH][IMAGE_WIDTH];
    pix_t              win      [NCH][3][3];
    pix_t              s1_win   [NCH][3][3];
    logic              win_valid;
    logic              s1_valid;
    logic signed [9:0] result   [NCH];
`ifdef SOBEL_BORDER_MASK_EN
    logic              border_now;
    logic              win_border;
    logic              s1_border;
`endif

    // a + 2b + c on zero-extended samples; maximum 1020 fits in 10 bits
    function automatic logic [9:0] weigh(input pix_t a, input pix_t b, input pix_t c);
        return 10'(a) + {1'b0, b, 1'b0} + 10'(c);
    endfunction

    // Gather the incoming pixel per channel; a start of frame addresses column 0
    always_comb begin
        new_px[0] = in_red;
        new_px[1] = in_green;
        new_px[2] = in_blue;
        col_idx   = in_sof ? '0 : col;
`ifdef SOBEL_BORDER_MASK_EN
        border_now = in_sof || (row < 2'd2) || (col < COL_W'(2));
`endif
    end

    // Column/row position of the next pixel; row saturates once the window is full height
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (in_sof) begin
                col <= COL_W'(1);
                row <= '0;
            end else if (col == COL_W'(IMAGE_WIDTH - 1)) begin
                col <= '0;
                if (row != 2'd2) begin
                    row <= row + 2'd1;
                end
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Two previous lines per channel; deliberately not reset
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                linebuf1[ch][col_idx] <= linebuf0[ch][col_idx];
                linebuf0[ch][col_idx] <= new_px[ch];
            end
        end
    end

    // Shift the 3x3 window left; new right column is (line-2, line-1, current)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    for (int unsigned c = 0; c < 3; c++) begin
                        win[ch][r][c] <= '0;
                    end
                end
            end
        end else if (in_valid) begin
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    win[ch][r][0] <= win[ch][r][1];
                    win[ch][r][1] <= win[ch][r][2];
                end
                win[ch][0][2] <= linebuf1[ch][col_idx];
                win[ch][1][2] <= linebuf0[ch][col_idx];
                win[ch][2][2] <= new_px[ch];
            end
        end
    end

    // Stage 1: snapshot the window so it can keep shifting while stage 2 computes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_valid <= 1'b0;
            s1_valid  <= 1'b0;
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    for (int unsigned c = 0; c < 3; c++) begin
                        s1_win[ch][r][c] <= '0;
                    end
                end
            end
`ifdef SOBEL_BORDER_MASK_EN
            win_border <= 1'b0;
            s1_border  <= 1'b0;
`endif
        end else begin
            win_valid <= in_valid;
            s1_valid  <= win_valid;
            if (win_valid) begin
                s1_win <= win;
            end
`ifdef SOBEL_BORDER_MASK_EN
            if (in_valid) begin
                win_border <= border_now;
            end
            if (win_valid) begin
                s1_border <= win_border;
            end
`endif
        end
    end

    // Sobel arithmetic: 11-bit signed difference halved into the 10-bit result
    always_comb begin : sobel_calc
        logic [9:0]         pos;
        logic [9:0]         neg;
        logic signed [10:0] diff;
        pos = '0;
        neg = '0;
        diff = '0;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            if (KERNEL_DIR == 0) begin
                pos = weigh(s1_win[ch][0][2], s1_win[ch][1][2], s1_win[ch][2][2]);
                neg = weigh(s1_win[ch][0][0], s1_win[ch][1][0], s1_win[ch][2][0]);
            end else begin
                pos = weigh(s1_win[ch][2][0], s1_win[ch][2][1], s1_win[ch][2][2]);
                neg = weigh(s1_win[ch][0][0], s1_win[ch][0][1], s1_win[ch][0][2]);
            end
            diff = $signed({1'b0, pos}) - $signed({1'b0, neg});
            result[ch] = 10'(diff >>> 1);
`ifdef SOBEL_BORDER_MASK_EN
            if (s1_border) begin
                result[ch] = '0;
            end
`endif
        end
    end

    // Stage 2: register results; outputs hold between valid pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            red_output   <= '0;
            green_output <= '0;
            blue_output  <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                red_output   <= result[0];
                green_output <= result[1];
                blue_output  <= result[2];
            end
        end
    end

endmodule

// File: tb/tb_sobel_gradient_engine.sv
// tb_sobel_gradient_engine: Gx and Gy instances fed identical streams, checked
// against a frame-level convolution model with a two-cycle output latency.
module tb_sobel_gradient_engine;
    localparam int W = 8;
`ifdef SOBEL_BORDER_MASK_EN
    localparam bit MASKED = 1'b1;
`else
    localparam bit MASKED = 1'b0;
`endif
    localparam int KX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    localparam int KY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

    typedef struct packed {
        logic            v;
        logic            chk;
        logic [2:0][9:0] gx;
        logic [2:0][9:0] gy;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_sof;
    logic [7:0]      in_red;
    logic [7:0]      in_green;
    logic [7:0]      in_blue;
    logic            vx;
    logic            vy;
    logic [2:0][9:0] gotx;
    logic [2:0][9:0] goty;

    exp_t            exp_q [$];
    int unsigned     vectors = 0;
    int unsigned     miscompares = 0;
    int              mrow;
    int              mcol;
    logic [2:0][7:0] img [3][W];

    always #5 clk = ~clk;

    sobel_gradient_engine #(.IMAGE_WIDTH(W), .KERNEL_DIR(0)) dut_x (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .out_valid(vx), .red_output(gotx[0]), .green_output(gotx[1]), .blue_output(gotx[2])
    );

    sobel_gradient_engine #(.IMAGE_WIDTH(W), .KERNEL_DIR(1)) dut_y (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .out_valid(vy), .red_output(goty[0]), .green_output(goty[1]), .blue_output(goty[2])
    );

    function automatic int pix(int r, int c, int ch);
        logic [2:0][7:0] p;
        p = img[r % 3][c];
        return int'(p[ch]);
    endfunction

    // Frame-level model: remember the last three lines, convolve around (row-1, col-1)
    task automatic model_cycle(input logic v, input logic sof, input logic [2:0][7:0] px);
        exp_t e;
        int   sx;
        int   sy;
        e = '0;
        if (v) begin
            if (sof) begin
                mrow = 0;
                mcol = 0;
            end
            img[mrow % 3][mcol] = px;
            e.v = 1'b1;
            if (mrow < 2 || mcol < 2) begin
                e.chk = MASKED;
            end else begin
                e.chk = 1'b1;
                for (int ch = 0; ch < 3; ch++) begin
                    sx = 0;
                    sy = 0;
                    for (int i = 0; i < 3; i++) begin
                        for (int j = 0; j < 3; j++) begin
                            sx += KX[i][j] * pix(mrow - 2 + i, mcol - 2 + j, ch);
                            sy += KY[i][j] * pix(mrow - 2 + i, mcol - 2 + j, ch);
                        end
                    end
                    e.gx[ch] = 10'(sx >>> 1);
                    e.gy[ch] = 10'(sy >>> 1);
                end
            end
            mcol++;
            if (mcol == W) begin
                mcol = 0;
                mrow++;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        mrow = 0;
        mcol = 0;
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
    endtask

    task automatic apply(input logic v, input logic sof, input logic [2:0][7:0] px);
        in_valid = v;
        in_sof   = sof;
        in_red   = px[0];
        in_green = px[1];
        in_blue  = px[2];
        @(posedge clk);
        model_cycle(v, sof, px);
        #1;
    endtask

    function automatic logic [2:0][7:0] pattern_px(int pat, int c);
        logic [2:0][7:0] p;
        case (pat)
            0: p = {8'd100, 8'd100, 8'd100};
            1: p = (c < 4) ? '0 : {8'd200, 8'd200, 8'd200};
            2: p = {8'd0, 8'd0, (c < 4) ? 8'd255 : 8'd0};
            3: p = {8'($urandom_range(0, 1) * 255), 8'($urandom), 8'($urandom_range(0, 1) * 255)};
            default: p = 24'($urandom);
        endcase
        return p;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        apply(1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (vx !== 1'b0 || vy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset out_valid got x=%b y=%b expected 0", vx, vy);
        end
        vectors++;
        if (gotx !== '0 || goty !== '0) begin
            miscompares++;
            $display("FAIL reset outputs got gx=%h gy=%h expected 0", gotx, goty);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Flat, rising step, falling red step, saturated random, full random frames
    task automatic test_patterns();
        exp_t e;
        for (int pat = 0; pat < 5; pat++) begin
            for (int i = 0; i < W * 6 + 2; i++) begin
                if (i < W * 6) apply(1'b1, i == 0, pattern_px(pat, i % W));
                else apply(1'b0, 1'b0, '0);
                e = exp_q.pop_front();
                vectors++;
                if (vx !== e.v || vy !== e.v) begin
                    miscompares++;
                    $display("FAIL patterns[%0d] out_valid got x=%b y=%b expected %b", pat, vx, vy, e.v);
                end else if (e.v && e.chk) begin
                    vectors++;
                    if (gotx !== e.gx || goty !== e.gy) begin
                        miscompares++;
                        $display("FAIL patterns[%0d] gradient got gx=%h gy=%h expected gx=%h gy=%h",
                                 pat, gotx, goty, e.gx, e.gy);
                    end
                end
            end
        end
    endtask

    // Alternate-cycle and random gaps; idle cycles carry junk pixels and stray in_sof
    task automatic test_gaps();
        exp_t e;
        int   n;
        int   cyc;
        logic v;
        for (int mode = 0; mode < 3; mode++) begin
            n = 0;
            cyc = 0;
            while (n < W * 6 || cyc < 2) begin
                if (n >= W * 6) begin
                    cyc++;
                    apply(1'b0, 1'b0, '0);
                end else begin
                    v = (mode == 0) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
                    if (mode == 0) cyc++;
                    if (v) begin
                        apply(1'b1, n == 0, pattern_px((mode == 0) ? 1 : 4, n % W));
                        n++;
                    end else begin
                        apply(1'b0, 1'($urandom_range(0, 1)), 24'($urandom));
                    end
                    if (n >= W * 6) cyc = 0;
                end
                e = exp_q.pop_front();
                vectors++;
                if (vx !== e.v || vy !== e.v) begin
                    miscompares++;
                    $display("FAIL gaps[%0d] out_valid got x=%b y=%b expected %b", mode, vx, vy, e.v);
                end else if (e.v && e.chk) begin
                    vectors++;
                    if (gotx !== e.gx || goty !== e.gy) begin
                        miscompares++;
                        $display("FAIL gaps[%0d] gradient got gx=%h gy=%h expected gx=%h gy=%h",
                                 mode, gotx, goty, e.gx, e.gy);
                    end
                end
            end
        end
    endtask

    // New frame started at row 3, column 5 of a random frame
    task automatic test_sof_restart();
        exp_t e;
        int   n;
        n = 0;
        while (n < 3 * W + 5 + 4 * W + 2) begin
            if (n < 3 * W + 5) begin
                apply(1'b1, n == 0, pattern_px(4, 0));
                n++;
            end else if (n < 3 * W + 5 + 4 * W) begin
                if (n == 3 * W + 5 || $urandom_range(0, 3) != 0) begin
                    apply(1'b1, n == 3 * W + 5, pattern_px(4, 0));
                    n++;
                end else begin
                    apply(1'b0, 1'b0, 24'($urandom));
                end
            end else begin
                apply(1'b0, 1'b0, '0);
                n++;
            end
            e = exp_q.pop_front();
            vectors++;
            if (vx !== e.v || vy !== e.v) begin
                miscompares++;
                $display("FAIL sof_restart out_valid got x=%b y=%b expected %b", vx, vy, e.v);
            end else if (e.v && e.chk) begin
                vectors++;
                if (gotx !== e.gx || goty !== e.gy) begin
                    miscompares++;
                    $display("FAIL sof_restart gradient got gx=%h gy=%h expected gx=%h gy=%h",
                             gotx, goty, e.gx, e.gy);
                end
            end
        end
    endtask

    // Asynchronous reset partway through row 4, then a fresh frame with no in_sof
    task automatic test_reset_mid_frame();
        exp_t e;
        for (int i = 0; i < 4 * W + 3; i++) begin
            apply(1'b1, i == 0, pattern_px(4, 0));
            e = exp_q.pop_front();
            vectors++;
            if (vx !== e.v || vy !== e.v) begin
                miscompares++;
                $display("FAIL reset_mid pre out_valid got x=%b y=%b expected %b", vx, vy, e.v);
            end else if (e.v && e.chk) begin
                vectors++;
                if (gotx !== e.gx || goty !== e.gy) begin
                    miscompares++;
                    $display("FAIL reset_mid pre gradient got gx=%h gy=%h expected gx=%h gy=%h",
                             gotx, goty, e.gx, e.gy);
                end
            end
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (vx !== 1'b0 || vy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid async out_valid got x=%b y=%b expected 0", vx, vy);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (vx !== 1'b0 || vy !== 1'b0 || gotx !== '0 || goty !== '0) begin
                miscompares++;
                $display("FAIL reset_mid hold got vx=%b vy=%b gx=%h gy=%h expected all 0", vx, vy, gotx, goty);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int n = 0; n < 4 * W + 2; ) begin
            if (n >= 4 * W) begin
                apply(1'b0, 1'b0, '0);
                n++;
            end else if ($urandom_range(0, 3) != 0) begin
                apply(1'b1, 1'b0, pattern_px(4, 0));
                n++;
            end else begin
                apply(1'b0, 1'b0, 24'($urandom));
            end
            e = exp_q.pop_front();
            vectors++;
            if (vx !== e.v || vy !== e.v) begin
                miscompares++;
                $display("FAIL reset_mid post out_valid got x=%b y=%b expected %b", vx, vy, e.v);
            end else if (e.v && e.chk) begin
                vectors++;
                if (gotx !== e.gx || goty !== e.gy) begin
                    miscompares++;
                    $display("FAIL reset_mid post gradient got gx=%h gy=%h expected gx=%h gy=%h",
                             gotx, goty, e.gx, e.gy);
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_red   = '0;
        in_green = '0;
        in_blue  = '0;
        mrow     = 0;
        mcol     = 0;
        test_reset();
        test_patterns();
        test_gaps();
        test_sof_restart();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
